// File: rtl/cga_comp_timing.sv
// cga_comp_timing -- character-rate sequencer for the CGA composite encoder.
//
// Purpose:
//   Derives the encoder's hclk/lclk character strobes from the 28.636 MHz
//   system clock, walks a character/line raster, and produces hsync,
//   active-low vsync, display enable and border-gated pixel data. Config
//   writes (B/W mode, border colour) are staged and only take effect at the
//   frame wrap, so a frame is never rendered with mixed settings.
//
// Optional feature (macro CGA_COMP_TIMING_BLINK_EN):
//   Defined   : a 4-bit frame counter advances on each frame_start and blink
//               toggles every time it wraps 15->0 (32-frame blink period).
//   Undefined : no counter is built and blink is tied low.
//
// Ports:
//   clk          in   system clock (28.636 MHz)
//   reset        in   synchronous, active-high
//   cfg_we       in   one-cycle config write strobe
//   cfg_bw       in   staged black-and-white mode
//   cfg_border   in   staged IRGB border colour
//   cfg_pending  out  staged config not yet applied
//   pix_in       in   IRGB pixel from the fetch pipeline
//   hclk         out  one-cycle strobe every 16 clk
//   lclk         out  one-cycle strobe every 32 clk (coincides with hclk)
//   hsync        out  active-high horizontal sync (registered)
//   vsync_l      out  active-low vertical sync (registered)
//   de           out  display enable (registered)
//   video        out  pix_in while displaying, border colour otherwise
//   bw_mode      out  applied B/W mode
//   hcount       out  current character column
//   vcount       out  current line
//   frame_start  out  one-cycle pulse after the raster wraps to (0,0)
//   blink        out  blink phase (see optional feature)

module cga_comp_timing #(
  parameter int H_TOTAL     = 57,
  parameter int H_DISP      = 40,
  parameter int HSYNC_START = 45,
  parameter int HSYNC_WIDTH = 10,
  parameter int V_TOTAL     = 262,
  parameter int V_DISP      = 200,
  parameter int VSYNC_START = 224,
  parameter int VSYNC_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic       cfg_bw,
  input  logic [3:0] cfg_border,
  output logic       cfg_pending,
  input  logic [3:0] pix_in,
  output logic       hclk,
  output logic       lclk,
  output logic       hsync,
  output logic       vsync_l,
  output logic       de,
  output logic [3:0] video,
  output logic       bw_mode,
  output logic [6:0] hcount,
  output logic [8:0] vcount,
  output logic       frame_start,
  output logic       blink
);

  // Window bounds widened by one bit so START+WIDTH cannot overflow.
  localparam logic [6:0] H_LAST   = 7'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [7:0] H_DISP_W = 8'(H_DISP);
  localparam logic [7:0] HS_BEG   = 8'(HSYNC_START);
  localparam logic [7:0] HS_END   = 8'(HSYNC_START + HSYNC_WIDTH);
  localparam logic [9:0] V_DISP_W = 10'(V_DISP);
  localparam logic [9:0] VS_BEG   = 10'(VSYNC_START);
  localparam logic [9:0] VS_END   = 10'(VSYNC_START + VSYNC_WIDTH);

  logic [4:0] pre_q, pre_d;
  logic [6:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_l_q, vsync_l_d;
  logic       de_q, de_d;
  logic [3:0] video_q, video_d;
  logic       frame_start_q, frame_start_d;
  logic       bw_q, bw_d;
  logic [3:0] border_q, border_d;
  logic       stage_bw_q, stage_bw_d;
  logic [3:0] stage_border_q, stage_border_d;
  logic       pending_q, pending_d;

  logic       lclk_w;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic [7:0] hcount_w;
  logic [9:0] vcount_w;

  // Strobes are decoded straight from the prescaler so they line up with
  // the cycle in which the counters are about to advance.
  assign lclk_w     = (pre_q == 5'd31);
  assign h_wrap     = (hcount_q == H_LAST);
  assign v_wrap     = (vcount_q == V_LAST);
  assign frame_wrap = lclk_w && h_wrap && v_wrap;
  assign hcount_w   = {1'b0, hcount_q};
  assign vcount_w   = {1'b0, vcount_q};

  // Prescaler and raster counters.
  always_comb begin
    pre_d    = pre_q + 5'd1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (lclk_w) begin
      if (h_wrap) begin
        hcount_d = 7'd0;
        vcount_d = v_wrap ? 9'd0 : vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 7'd1;
      end
    end
  end

  // Sync/enable/pixel decode. These are registered, so they lag the
  // counters by one clk; frame_start lands in the cycle after the wrap.
  always_comb begin
    hsync_d       = (hcount_w >= HS_BEG) && (hcount_w < HS_END);
    vsync_l_d     = !((vcount_w >= VS_BEG) && (vcount_w < VS_END));
    de_d          = (hcount_w < H_DISP_W) && (vcount_w < V_DISP_W);
    video_d       = de_d ? pix_in : border_q;
    frame_start_d = frame_wrap;
  end

  // Config staging. At a frame wrap the previously staged value is applied;
  // a write in that same cycle still lands in staging and keeps pending set.
  always_comb begin
    stage_bw_d     = stage_bw_q;
    stage_border_d = stage_border_q;
    pending_d      = pending_q;
    bw_d           = bw_q;
    border_d       = border_q;
    if (frame_wrap && pending_q) begin
      bw_d      = stage_bw_q;
      border_d  = stage_border_q;
      pending_d = 1'b0;
    end
    if (cfg_we) begin
      stage_bw_d     = cfg_bw;
      stage_border_d = cfg_border;
      pending_d      = 1'b1;
    end
  end

  // State registers; reset also drops any staged config.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q          <= 5'd0;
      hcount_q       <= 7'd0;
      vcount_q       <= 9'd0;
      hsync_q        <= 1'b0;
      vsync_l_q      <= 1'b1;
      de_q           <= 1'b0;
      video_q        <= 4'd0;
      frame_start_q  <= 1'b0;
      bw_q           <= 1'b0;
      border_q       <= 4'd0;
      stage_bw_q     <= 1'b0;
      stage_border_q <= 4'd0;
      pending_q      <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      hsync_q        <= hsync_d;
      vsync_l_q      <= vsync_l_d;
      de_q           <= de_d;
      video_q        <= video_d;
      frame_start_q  <= frame_start_d;
      bw_q           <= bw_d;
      border_q       <= border_d;
      stage_bw_q     <= stage_bw_d;
      stage_border_q <= stage_border_d;
      pending_q      <= pending_d;
    end
  end

`ifdef CGA_COMP_TIMING_BLINK_EN
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       blink_q, blink_d;

  // Blink phase flips each time the 16-frame counter rolls over.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start_q) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
      if (frame_cnt_q == 4'd15) begin
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 4'd0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign hclk        = (pre_q[3:0] == 4'hf);
  assign lclk        = lclk_w;
  assign hsync       = hsync_q;
  assign vsync_l     = vsync_l_q;
  assign de          = de_q;
  assign video       = video_q;
  assign bw_mode     = bw_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign cfg_pending = pending_q;

endmodule

// File: tb/tb_cga_comp_timing.sv
// Testbench for cga_comp_timing using a reduced raster so whole frames fit
// in a short run: 12 characters x 10 lines, 32 clk per character, so one
// line is 384 clk and one frame is 3840 clk.
//   Display   : hcount 0..7,  vcount 0..5
//   hsync     : hcount 9..10  (64 clk)
//   vsync_l   : vcount 7..8   (768 clk low)
// "Cycle n" means n clk edges after the last edge that sampled reset high.

module tb_cga_comp_timing;

  localparam int HT = 12;
  localparam int HD = 8;
  localparam int HSS = 9;
  localparam int HSW = 2;
  localparam int VT = 10;
  localparam int VD = 6;
  localparam int VSS = 7;
  localparam int VSW = 2;

  logic       clk;
  logic       reset;
  logic       cfgWe;
  logic       cfgBw;
  logic [3:0] cfgBorder;
  logic       cfgPending;
  logic [3:0] pixIn;
  logic       hclk;
  logic       lclk;
  logic       hsync;
  logic       vsyncL;
  logic       de;
  logic [3:0] video;
  logic       bwMode;
  logic [6:0] hcount;
  logic [8:0] vcount;
  logic       frameStart;
  logic       blink;

  int checksTotal;
  int checksPassed;
  int cur;

  cga_comp_timing #(
    .H_TOTAL(HT), .H_DISP(HD), .HSYNC_START(HSS), .HSYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_DISP(VD), .VSYNC_START(VSS), .VSYNC_WIDTH(VSW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfgWe),
    .cfg_bw(cfgBw),
    .cfg_border(cfgBorder),
    .cfg_pending(cfgPending),
    .pix_in(pixIn),
    .hclk(hclk),
    .lclk(lclk),
    .hsync(hsync),
    .vsync_l(vsyncL),
    .de(de),
    .video(video),
    .bw_mode(bwMode),
    .hcount(hcount),
    .vcount(vcount),
    .frame_start(frameStart),
    .blink(blink)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cur, actual, expected);
    end
  endtask

  // Advance to 2 ns after the edge that starts cycle k.
  task automatic goToCycle(input int k);
    if (cur < k) begin
      while (cur < k) begin
        @(posedge clk);
        cur++;
      end
      #2;
    end
  endtask

  // One-cycle config write starting in the current cycle.
  task automatic applyStimulus(input logic bw, input logic [3:0] border);
    cfgWe     = 1'b1;
    cfgBw     = bw;
    cfgBorder = border;
    @(posedge clk);
    cur++;
    #2;
    cfgWe     = 1'b0;
  endtask

  // One-cycle reset; afterwards the bench sits in cycle 0.
  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    cur   = 0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_hcount",  16'(hcount),     16'd0);
    checkOutput("rst_vcount",  16'(vcount),     16'd0);
    checkOutput("rst_hclk",    16'(hclk),       16'd0);
    checkOutput("rst_lclk",    16'(lclk),       16'd0);
    checkOutput("rst_hsync",   16'(hsync),      16'd0);
    checkOutput("rst_vsync_l", 16'(vsyncL),     16'd1);
    checkOutput("rst_de",      16'(de),         16'd0);
    checkOutput("rst_video",   16'(video),      16'd0);
    checkOutput("rst_bw",      16'(bwMode),     16'd0);
    checkOutput("rst_pending", 16'(cfgPending), 16'd0);
    checkOutput("rst_fstart",  16'(frameStart), 16'd0);
    checkOutput("rst_blink",   16'(blink),      16'd0);
  endtask

  // Main sequence: timing over one full frame, config staging, reset.
  initial begin
    int hsCount;
    int hsFirst;
    int deLine0;
    int vsLow;
    int deFrame;
    int vidA;
    int vidZero;
    int fsCount;

    checksTotal  = 0;
    checksPassed = 0;
    cur          = 0;
    reset        = 1'b1;
    cfgWe        = 1'b0;
    cfgBw        = 1'b0;
    cfgBorder    = 4'd0;
    pixIn        = 4'hA;
    hsCount      = 0;
    hsFirst      = -1;
    deLine0      = 0;
    vsLow        = 0;
    deFrame      = 0;
    vidA         = 0;
    vidZero      = 0;
    fsCount      = 0;

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    cur   = 0;
    $display("[TB] reset released");

    // Walk the whole first frame plus one cycle.
    for (int c = 0; c <= 3841; c++) begin
      goToCycle(c);
      if (c < 384) begin
        if (hsync) begin
          hsCount++;
          if (hsFirst < 0) hsFirst = c;
        end
        if (de) deLine0++;
      end
      if (c < 3840) begin
        if (!vsyncL) vsLow++;
        if (de) deFrame++;
        if (video == 4'hA) vidA++;
        if (video == 4'h0) vidZero++;
      end
      if (frameStart) fsCount++;
      case (c)
        0:    checkResetState();
        1: begin
          checkOutput("de_first",    16'(de),    16'd1);
          checkOutput("video_first", 16'(video), 16'hA);
        end
        15: begin
          checkOutput("hclk_15", 16'(hclk), 16'd1);
          checkOutput("lclk_15", 16'(lclk), 16'd0);
        end
        16:   checkOutput("hclk_16", 16'(hclk), 16'd0);
        31: begin
          checkOutput("hclk_31", 16'(hclk), 16'd1);
          checkOutput("lclk_31", 16'(lclk), 16'd1);
        end
        32: begin
          checkOutput("hcount_32", 16'(hcount), 16'd1);
          checkOutput("lclk_32",   16'(lclk),   16'd0);
        end
        47:   checkOutput("hclk_47", 16'(hclk), 16'd1);
        63:   checkOutput("lclk_63", 16'(lclk), 16'd1);
        256:  checkOutput("de_256",  16'(de),   16'd1);
        257: begin
          checkOutput("de_257",    16'(de),    16'd0);
          checkOutput("video_257", 16'(video), 16'd0);
        end
        288:  checkOutput("hsync_288", 16'(hsync), 16'd0);
        289:  checkOutput("hsync_289", 16'(hsync), 16'd1);
        300:  checkOutput("vsync_l_300", 16'(vsyncL), 16'd1);
        352:  checkOutput("hsync_352", 16'(hsync), 16'd1);
        353:  checkOutput("hsync_353", 16'(hsync), 16'd0);
        384: begin
          checkOutput("vcount_384", 16'(vcount), 16'd1);
          checkOutput("hcount_384", 16'(hcount), 16'd0);
        end
        2305: begin
          checkOutput("vcount_2305", 16'(vcount), 16'd6);
          checkOutput("de_2305",     16'(de),     16'd0);
        end
        2688: checkOutput("vsync_l_2688", 16'(vsyncL), 16'd1);
        2689: checkOutput("vsync_l_2689", 16'(vsyncL), 16'd0);
        3456: checkOutput("vsync_l_3456", 16'(vsyncL), 16'd0);
        3457: checkOutput("vsync_l_3457", 16'(vsyncL), 16'd1);
        3839: checkOutput("fstart_3839", 16'(frameStart), 16'd0);
        3840: begin
          checkOutput("fstart_3840", 16'(frameStart), 16'd1);
          checkOutput("hcount_3840", 16'(hcount),     16'd0);
          checkOutput("vcount_3840", 16'(vcount),     16'd0);
        end
        3841: checkOutput("fstart_3841", 16'(frameStart), 16'd0);
        default: ;
      endcase
    end

    checkOutput("hsync_width",  16'(hsCount), 16'd64);
    checkOutput("hsync_first",  16'(hsFirst), 16'd289);
    checkOutput("de_line0",     16'(deLine0), 16'd256);
    checkOutput("vsync_low",    16'(vsLow),   16'd768);
    checkOutput("de_frame",     16'(deFrame), 16'd1536);
    checkOutput("video_a",      16'(vidA),    16'd1536);
    checkOutput("video_border", 16'(vidZero), 16'd2304);
    checkOutput("fstart_count", 16'(fsCount), 16'd1);

    // Mid-frame write: held until the wrap at the end of frame 1.
    goToCycle(4000);
    applyStimulus(1'b1, 4'h1);
    checkOutput("cfg1_pending", 16'(cfgPending), 16'd1);
    checkOutput("cfg1_bw_hold", 16'(bwMode),     16'd0);
    goToCycle(4100);
    checkOutput("cfg1_border_hold", 16'(video), 16'h0);
    goToCycle(7679);
    checkOutput("cfg1_bw_prewrap", 16'(bwMode),     16'd0);
    checkOutput("cfg1_pend_prewrap", 16'(cfgPending), 16'd1);
    goToCycle(7680);
    checkOutput("cfg1_fstart",     16'(frameStart), 16'd1);
    checkOutput("cfg1_bw_applied", 16'(bwMode),     16'd1);
    checkOutput("cfg1_pend_clear", 16'(cfgPending), 16'd0);
    goToCycle(7940);
    checkOutput("cfg1_border_applied", 16'(video), 16'h1);

    // Stage border 2, then write border 6 in the exact wrap cycle.
    goToCycle(8000);
    applyStimulus(1'b0, 4'h2);
    checkOutput("cfg2_pending", 16'(cfgPending), 16'd1);
    goToCycle(11519);
    applyStimulus(1'b1, 4'h6);
    checkOutput("wrap_fstart",  16'(frameStart), 16'd1);
    checkOutput("wrap_pending", 16'(cfgPending), 16'd1);
    checkOutput("wrap_bw",      16'(bwMode),     16'd0);
    goToCycle(11820);
    checkOutput("wrap_border_old", 16'(video), 16'h2);
    goToCycle(15360);
    checkOutput("wrap2_pending", 16'(cfgPending), 16'd0);
    checkOutput("wrap2_bw",      16'(bwMode),     16'd1);
    goToCycle(15660);
    checkOutput("wrap2_border_new", 16'(video), 16'h6);

    // Reset mid-frame with a write pending.
    goToCycle(15400);
    applyStimulus(1'b0, 4'h9);
    goToCycle(16680);
    checkOutput("pre_rst_hcount",  16'(hcount),     16'd5);
    checkOutput("pre_rst_vcount",  16'(vcount),     16'd3);
    checkOutput("pre_rst_pending", 16'(cfgPending), 16'd1);
    applyReset();
    checkResetState();
    goToCycle(300);
    checkOutput("post_rst_border", 16'(video), 16'h0);
    goToCycle(4140);
    checkOutput("post_rst_border_f2", 16'(video),  16'h0);
    checkOutput("post_rst_bw_f2",     16'(bwMode), 16'd0);

`ifdef CGA_COMP_TIMING_BLINK_EN
    // 16th frame_start lands at cycle 16*3840; blink flips one clk later.
    goToCycle(61440);
    checkOutput("blink_before", 16'(blink), 16'd0);
    goToCycle(61441);
    checkOutput("blink_after",  16'(blink), 16'd1);
`else
    checkOutput("blink_tied", 16'(blink), 16'd0);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
